// File: rtl/jk_excite_driver.sv
// Excitation driver for a JK flip-flop bank. Buffers target words and derives J/K from the bank's
// current Q so each target lands in one clock, then checks Q feedback for mismatches.
module jk_excite_driver #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TOGGLE_EXC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [WIDTH-1:0]           q_fb,
  output logic [WIDTH-1:0]           j,
  output logic [WIDTH-1:0]           k,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clear_err,
  output logic                       err,
  output logic [7:0]                 err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             init_q;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             full, empty, push, pop, mismatch;
  logic [WIDTH-1:0] head, diff, exc_j, exc_k;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  // Stays low until the first edge after reset release.
  assign in_ready = init_q & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = ((state_q == StIdle) || (state_q == StCheck)) && !empty;
  assign head     = mem[rd_ptr_q];

  assign j       = j_q;
  assign k       = k_q;
  assign level   = level_q;
  assign busy    = (state_q != StIdle) || !empty;
  assign err     = err_q;
  assign err_cnt = cnt_q;

  always_comb begin
    diff = q_fb ^ head;
    if (TOGGLE_EXC != 0) begin
      exc_j = diff;
      exc_k = diff;
    end else begin
      exc_j = diff & head;
      exc_k = diff & ~head;
    end
  end

  // An X/Z compare takes the else branch, so unknown feedback counts as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (q_fb == tgt_q) mismatch = 1'b0;
    else               mismatch = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    j_d     = '0;
    k_d     = '0;
    tgt_d   = tgt_q;
    case (state_q)
      StIdle, StCheck: begin
        if (pop) begin
          j_d     = exc_j;
          k_d     = exc_k;
          tgt_d   = head;
          state_d = StDrive;
        end else begin
          state_d = StIdle;
        end
      end
      StDrive: state_d = StCheck;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Clear is applied first so a same-edge mismatch still records as the first error.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (clear_err) begin
      err_d = 1'b0;
      cnt_d = 8'd0;
    end
    if ((state_q == StCheck) && mismatch) begin
      err_d = 1'b1;
      if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      init_q   <= 1'b0;
      state_q  <= StIdle;
      j_q      <= '0;
      k_q      <= '0;
      tgt_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      init_q  <= 1'b1;
      level_q <= level_d;
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: behavioural JK bank on the feedback path, a scoreboard of expected
// J/K drives checked as the DUT emits them, and directed timing/fault/reset sequences.
module tb_jk_excite_driver;

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] ej;
    logic [3:0] ek;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, clear_err, busy, err;
  logic [3:0] in_data, q_fb, j, k, bank_q, stuck;
  logic [2:0] level;
  logic [7:0] err_cnt;

  logic       t_valid, t_ready, t_busy, t_err;
  logic [3:0] t_data, t_j, t_k, t_bank;
  logic [2:0] t_level;
  logic [7:0] t_cnt;

  int   errors = 0;
  int   checks = 0;
  vec_t sb_q[$];
  vec_t rec;
  vec_t tbl[6];
  vec_t burst[8];
  bit   sb_en = 1'b1;
  bit   pend = 1'b0;
  logic [3:0] pend_tgt;

  always #5 clk = ~clk;

  assign q_fb = bank_q & ~stuck;

  jk_excite_driver #(.WIDTH(4), .DEPTH(4), .TOGGLE_EXC(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .q_fb(q_fb), .j(j), .k(k), .busy(busy), .level(level), .clear_err(clear_err),
    .err(err), .err_cnt(err_cnt)
  );

  jk_excite_driver #(.WIDTH(4), .DEPTH(4), .TOGGLE_EXC(1)) u_tgl (
    .clk(clk), .rst_n(rst_n), .in_valid(t_valid), .in_ready(t_ready), .in_data(t_data),
    .q_fb(t_bank), .j(t_j), .k(t_k), .busy(t_busy), .level(t_level), .clear_err(1'b0),
    .err(t_err), .err_cnt(t_cnt)
  );

  // Behavioural JK banks: Q+ = J&~Q | ~K&Q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      t_bank <= '0;
    end else begin
      bank_q <= (j & ~bank_q) | (~k & bank_q);
      t_bank <= (t_j & ~t_bank) | (~t_k & t_bank);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [3:0] ej, input logic [3:0] ek,
                      input bit track, output int waits);
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) chk("push_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    if (track) sb_q.push_back('{d, ej, ek});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every nonzero drive pops one expected record.
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (pend) begin
        chk("bank_after_drive", 32'(bank_q), 32'(pend_tgt));
        chk("drive_one_cycle", 32'({j, k}), 32'd0);
        pend = 1'b0;
      end
      if ((j | k) != 4'd0) begin
        chk("jk_never_both", 32'(j & k), 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_drive", 32'({j, k}), 32'd0);
        end else begin
          rec = sb_q.pop_front();
          chk("sb_j", 32'(j), 32'(rec.ej));
          chk("sb_k", 32'(k), 32'(rec.ek));
          pend     = 1'b1;
          pend_tgt = rec.tgt;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int nz;

    // Chain from Q=1010, ending at 0000.
    tbl[0] = '{4'b0110, 4'b0100, 4'b1000};
    tbl[1] = '{4'b1111, 4'b1001, 4'b0000};
    tbl[2] = '{4'b0000, 4'b0000, 4'b1111};
    tbl[3] = '{4'b0101, 4'b0101, 4'b0000};
    tbl[4] = '{4'b1010, 4'b1010, 4'b0101};
    tbl[5] = '{4'b0000, 4'b0000, 4'b1010};
    // Chain from Q=0000, ending at 0010.
    burst[0] = '{4'b0001, 4'b0001, 4'b0000};
    burst[1] = '{4'b0011, 4'b0010, 4'b0000};
    burst[2] = '{4'b0110, 4'b0100, 4'b0001};
    burst[3] = '{4'b1100, 4'b1000, 4'b0010};
    burst[4] = '{4'b1111, 4'b0011, 4'b0000};
    burst[5] = '{4'b1000, 4'b0000, 4'b0111};
    burst[6] = '{4'b0100, 4'b0100, 4'b1000};
    burst[7] = '{4'b0010, 4'b0010, 4'b0100};

    // Reset held with in_valid asserted.
    rst_n = 1'b0; in_valid = 1'b1; in_data = 4'hF; clear_err = 1'b0; stuck = 4'd0;
    t_valid = 1'b0; t_data = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_post_edge", 32'(in_ready), 32'd1);
    chk("rel_level", 32'(level), 32'd0);

    // Single target: first-transaction latency.
    in_valid = 1'b1; in_data = 4'b1010;
    sb_q.push_back('{4'b1010, 4'b1010, 4'b0000});
    @(negedge clk);
    in_valid = 1'b0;
    chk("single_level_e0", 32'(level), 32'd1);
    chk("single_j_e0", 32'(j), 32'd0);
    @(negedge clk);
    chk("single_j_e1", 32'(j), 32'b1010);
    chk("single_k_e1", 32'(k), 32'd0);
    chk("single_level_e1", 32'(level), 32'd0);
    chk("single_busy_e1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_j_e2", 32'(j), 32'd0);
    chk("single_bank_e2", 32'(bank_q), 32'b1010);
    @(negedge clk);
    chk("single_busy_e3", 32'(busy), 32'd0);
    chk("single_err_e3", 32'(err), 32'd0);

    // Table-driven targets, one at a time.
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].tgt, tbl[i].ej, tbl[i].ek, 1'b1, w);
      drain();
      chk("tbl_bank", 32'(bank_q), 32'(tbl[i].tgt));
      chk("tbl_err", 32'(err), 32'd0);
    end

    // Burst on consecutive cycles fills the FIFO and holds the 8th off for one cycle.
    for (int i = 0; i < 8; i++) begin
      push(burst[i].tgt, burst[i].ej, burst[i].ek, 1'b1, w);
      if (i == 6) begin
        chk("burst_level_full", 32'(level), 32'd4);
        chk("burst_ready_full", 32'(in_ready), 32'd0);
      end
      if (i == 7) chk("burst_holdoff_cycles", 32'(w), 32'd1);
    end
    drain();
    chk("burst_final_bank", 32'(bank_q), 32'b0010);
    chk("burst_err", 32'(err), 32'd0);

    // Toggle-mode instance: 0000 -> 1100 -> 0101.
    t_valid = 1'b1; t_data = 4'b1100;
    @(negedge clk);
    t_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("tgl_bank_1100", 32'(t_bank), 32'b1100);
    t_valid = 1'b1; t_data = 4'b0101;
    @(negedge clk);
    t_valid = 1'b0;
    @(negedge clk);
    chk("tgl_j", 32'(t_j), 32'b1001);
    chk("tgl_k", 32'(t_k), 32'b1001);
    @(negedge clk);
    chk("tgl_bank_0101", 32'(t_bank), 32'b0101);
    @(negedge clk);
    chk("tgl_err", 32'(t_err), 32'd0);
    chk("tgl_busy", 32'(t_busy), 32'd0);

    // Feedback bit0 stuck at 0: every check mismatches.
    sb_en = 1'b0;
    stuck = 4'b0001;
    push(4'b0001, 4'd0, 4'd0, 1'b0, w);
    repeat (3) @(negedge clk);
    chk("fault_err_first", 32'(err), 32'd1);
    chk("fault_cnt_first", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 299; i++) push(4'b0001, 4'd0, 4'd0, 1'b0, w);
    drain();
    chk("fault_cnt_sat", 32'(err_cnt), 32'd255);
    chk("fault_err_sticky", 32'(err), 32'd1);

    // Clear on the same edge as a mismatch: mismatch wins.
    push(4'b0001, 4'd0, 4'd0, 1'b0, w);
    @(negedge clk);
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clr_vs_mis_err", 32'(err), 32'd1);
    chk("clr_vs_mis_cnt", 32'(err_cnt), 32'd1);
    drain();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_err", 32'(err), 32'd0);
    chk("clear_cnt", 32'(err_cnt), 32'd0);
    stuck = 4'd0;

    // Reset while driving: j/k drop at once and queued targets are lost.
    push(4'b1000, 4'd0, 4'd0, 1'b0, w);
    push(4'b0100, 4'd0, 4'd0, 1'b0, w);
    chk("mid_j_driving", 32'(j), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_j", 32'(j), 32'd0);
    chk("mid_rst_k", 32'(k), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((j | k) != 4'd0) nz++;
    end
    chk("mid_no_drive_after", 32'(nz), 32'd0);
    chk("mid_level_after", 32'(level), 32'd0);
    chk("mid_err_after", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
